// File: rtl/mem_access_unit.sv
// Memory-stage load/store controller: turns MEM-stage loads/stores into a req/ready bus transfer and extends load data into Mout.
// Latency: IDLE -> WAIT (one cycle per bus wait state) -> DONE; minimum 2 stall cycles, Mout valid in DONE.
// Backpressure: stall held while the access is seen in IDLE and throughout WAIT; optional MEM_MISALIGN_TRAP_EN flags misaligned H/W accesses instead of issuing them.
module mem_access_unit #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   AluOut,
    input  logic [31:0]   storeData,
    input  logic          memRead,
    input  logic          memWrite,
    input  logic [2:0]    funct3,
    output logic [31:0]   Mout,
    output logic          stall,
    output logic          misalign,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [3:0]    dmem_be,
    output logic [31:0]   dmem_wdata,
    input  logic          dmem_ready,
    input  logic [31:0]   dmem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    state_t          state_q, state_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [1:0]      off_q, off_d;
    logic [31:0]     mout_q, mout_d;

    logic            access;
    logic            trap;
    logic            is_b, is_h, is_w;
    logic [1:0]      off;
    logic [1:0]      size_new;
    logic [3:0]      be_new;
    logic [31:0]     wdata_new;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_ext;

    // Decode size/sign of the incoming access and build its bus fields.
    // 011/110/111 fall through to word; the offset is forced to natural alignment.
    always_comb begin
        is_b      = (funct3[1:0] == 2'b00);
        is_h      = (funct3[1:0] == 2'b01);
        is_w      = ~is_b & ~is_h;
        access    = memRead | memWrite;
        off       = is_w ? 2'b00 : (is_h ? {AluOut[1], 1'b0} : AluOut[1:0]);
        size_new  = is_b ? SZ_B : (is_h ? SZ_H : SZ_W);
        be_new    = is_b ? (4'b0001 << off) : (is_h ? (4'b0011 << off) : 4'b1111);
        wdata_new = is_b ? {4{storeData[7:0]}} : (is_h ? {2{storeData[15:0]}} : storeData);
`ifdef MEM_MISALIGN_TRAP_EN
        trap      = (state_q == S_IDLE) & access &
                    ((is_h & AluOut[0]) | (is_w & (AluOut[1:0] != 2'b00)));
`else
        trap      = 1'b0;
`endif
    end

    // Select the byte/half lane of the returned word and extend it.
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (size_q)
            SZ_B:    ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
            SZ_H:    ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
            default: ld_ext = dmem_rdata;
        endcase
    end

    // Next-state logic: launch in IDLE, hold the bus in WAIT until ready, one DONE cycle.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        mout_d  = mout_q;
        case (state_q)
            S_IDLE: begin
                if (access && !trap) begin
                    state_d = S_WAIT;
                    req_d   = 1'b1;
                    we_d    = memWrite;
                    addr_d  = {AluOut[AW-1:2], 2'b00};
                    be_d    = be_new;
                    wdata_d = wdata_new;
                    size_d  = size_new;
                    uns_d   = funct3[2] & ~is_w;
                    off_d   = off;
                end
            end
            S_WAIT: begin
                if (dmem_ready) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    if (!we_q) mout_d = ld_ext;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered bus/result outputs; reset abandons any outstanding transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            mout_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            mout_q  <= mout_d;
        end
    end

    assign stall      = ((state_q == S_IDLE) & access & ~trap) | (state_q == S_WAIT);
    assign misalign   = trap;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign Mout       = mout_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: drives loads/stores, answers the bus with programmable wait states.
// Expected bus fields and Mout are queued at issue and compared when the request/DONE cycle appears.
// Every wait on the DUT is bounded; a timeout counts as a mismatch.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] AluOut, storeData, Mout, dmem_addr, dmem_wdata, dmem_rdata;
    logic        memRead, memWrite, stall, misalign, dmem_req, dmem_we, dmem_ready;
    logic [2:0]  funct3;
    logic [3:0]  dmem_be;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] mout;
        int          stalls;
    } txn_t;

    txn_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    mem_access_unit #(.AW(32)) dut (
        .clk(clk), .rst(rst), .AluOut(AluOut), .storeData(storeData),
        .memRead(memRead), .memWrite(memWrite), .funct3(funct3),
        .Mout(Mout), .stall(stall), .misalign(misalign),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Issue one access at posedge+1, answer the bus after 'waits' wait states, check request and result.
    task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
                         input int waits, input logic [31:0] e_addr, input logic [3:0] e_be,
                         input logic [31:0] e_wdata, input logic [31:0] e_mout, input int e_stall);
        txn_t t, cur;
        int   stall_cnt = 0;
        int   wait_ctr  = 0;
        int   cyc       = 0;
        bit   seen_req  = 0;
        bit   done      = 0;
        t.we = wr; t.addr = e_addr; t.be = e_be; t.wdata = e_wdata; t.mout = e_mout; t.stalls = e_stall;
        sb_q.push_back(t);
        memRead = rd; memWrite = wr; funct3 = f3; AluOut = addr; storeData = sd;
        while (!done && cyc < 60) begin
            #1;
            if (cyc == 0) chk("misalign_clear", {31'b0, misalign}, 32'h0);
            if (stall) stall_cnt++;
            if (dmem_req && !seen_req) begin
                seen_req = 1;
                if (sb_q.size() == 0) begin
                    chk("sb_empty", 32'h1, 32'h0);
                end else begin
                    cur = sb_q.pop_front();
                    chk("dmem_we",    {31'b0, dmem_we}, {31'b0, cur.we});
                    chk("dmem_addr",  dmem_addr, cur.addr);
                    chk("dmem_be",    {28'b0, dmem_be}, {28'b0, cur.be});
                    chk("dmem_wdata", dmem_wdata, cur.wdata);
                end
            end
            if (dmem_req) begin
                if (wait_ctr == waits) begin
                    dmem_ready = 1'b1;
                    dmem_rdata = rdata;
                end else begin
                    wait_ctr++;
                end
            end else if (seen_req && !stall) begin
                done = 1;
                chk("Mout",        Mout, cur.mout);
                chk("stall_count", stall_cnt, cur.stalls);
            end
            @(posedge clk);
            #1;
            dmem_ready = 1'b0;
            cyc++;
        end
        if (!done) chk("timeout", 32'h0, 32'h1);
        memRead = 1'b0; memWrite = 1'b0;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_Mout"},     Mout, 32'h0);
        chk({pfx, "_req"},      {31'b0, dmem_req}, 32'h0);
        chk({pfx, "_we"},       {31'b0, dmem_we}, 32'h0);
        chk({pfx, "_addr"},     dmem_addr, 32'h0);
        chk({pfx, "_be"},       {28'b0, dmem_be}, 32'h0);
        chk({pfx, "_wdata"},    dmem_wdata, 32'h0);
        chk({pfx, "_stall"},    {31'b0, stall}, 32'h0);
        chk({pfx, "_misalign"}, {31'b0, misalign}, 32'h0);
    endtask

    initial begin
        rst = 1'b0; AluOut = 0; storeData = 0; memRead = 0; memWrite = 0;
        funct3 = 3'b000; dmem_ready = 0; dmem_rdata = 0;
        #2;
        chk_reset_vals("rst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // LB, zero-wait, top byte sign-extended
        do_op(1, 0, 3'b000, 32'h1003, 32'h0, 32'h80FF_FF00, 0, 32'h1000, 4'b1000, 32'h0, 32'hFFFF_FF80, 2);
        // LHU, 3 wait states
        do_op(1, 0, 3'b101, 32'h2002, 32'h0, 32'h9234_5678, 3, 32'h2000, 4'b1100, 32'h0, 32'h0000_9234, 5);
        // SB replicates the low byte; Mout holds
        do_op(0, 1, 3'b000, 32'h0010, 32'h1234_56AB, 32'hFFFF_FFFF, 0, 32'h0010, 4'b0001, 32'hABAB_ABAB, 32'h0000_9234, 2);
        // SW then LW back-to-back
        do_op(0, 1, 3'b010, 32'h0020, 32'hDEAD_BEEF, 32'h0, 0, 32'h0020, 4'b1111, 32'hDEAD_BEEF, 32'h0000_9234, 2);
        do_op(1, 0, 3'b010, 32'h0024, 32'h0, 32'h1122_3344, 0, 32'h0024, 4'b1111, 32'h0, 32'h1122_3344, 2);
        // LH upper half, sign-extended
        do_op(1, 0, 3'b001, 32'h3002, 32'h0, 32'h8001_1234, 0, 32'h3000, 4'b1100, 32'h0, 32'hFFFF_8001, 2);
        // LBU byte 1, zero-extended
        do_op(1, 0, 3'b100, 32'h4001, 32'h0, 32'h0000_C300, 0, 32'h4000, 4'b0010, 32'h0, 32'h0000_00C3, 2);
        // SH upper half, replicated data
        do_op(0, 1, 3'b001, 32'h0052, 32'h1234_BEEF, 32'h0, 0, 32'h0050, 4'b1100, 32'hBEEF_BEEF, 32'h0000_00C3, 2);
        // funct3=111 behaves as word, one wait state
        do_op(1, 0, 3'b111, 32'h0060, 32'h0, 32'h5555_AAAA, 1, 32'h0060, 4'b1111, 32'h0, 32'h5555_AAAA, 3);

        // LW at 0x1001
`ifdef MEM_MISALIGN_TRAP_EN
        memRead = 1'b1; funct3 = 3'b010; AluOut = 32'h1001; storeData = 0;
        #1;
        chk("trap_misalign", {31'b0, misalign}, 32'h1);
        chk("trap_req",      {31'b0, dmem_req}, 32'h0);
        chk("trap_stall",    {31'b0, stall}, 32'h0);
        @(posedge clk); #1;
        chk("trap_req_hold", {31'b0, dmem_req}, 32'h0);
        chk("trap_Mout",     Mout, 32'h5555_AAAA);
        memRead = 1'b0;
        @(posedge clk); #1;
`else
        do_op(1, 0, 3'b010, 32'h1001, 32'h0, 32'h0BAD_F00D, 0, 32'h1000, 4'b1111, 32'h0, 32'h0BAD_F00D, 2);
`endif

        // Reset mid-WAIT, then a late ready must be ignored
        memRead = 1'b1; funct3 = 3'b010; AluOut = 32'h0700;
        @(posedge clk); #1;
        chk("wait_req", {31'b0, dmem_req}, 32'h1);
        #2 rst = 1'b0; memRead = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(posedge clk); #1 rst = 1'b1;
        dmem_ready = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1 dmem_ready = 1'b0;
        chk("late_ready_Mout",  Mout, 32'h0);
        chk("late_ready_req",   {31'b0, dmem_req}, 32'h0);
        chk("late_ready_stall", {31'b0, stall}, 32'h0);
        chk("sb_drained",       sb_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
